// File: rtl/mipi_rx_pkg.sv
// Shared constants for the CSI-2 RAW unpacker: format codes, group sizes, pixel geometry.
package mipi_rx_pkg;

  localparam int PIX_W        = 12;
  localparam int PIX_PER_BEAT = 4;
  localparam int GRP_MAX      = 6;   // largest group (RAW12) in bytes

  typedef enum logic [1:0] {
    MODE_RAW8  = 2'd0,
    MODE_RAW10 = 2'd1,
    MODE_RAW12 = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // Bytes consumed per four-pixel output beat
  localparam logic [2:0] G_RAW8  = 3'd4;
  localparam logic [2:0] G_RAW10 = 3'd5;
  localparam logic [2:0] G_RAW12 = 3'd6;

  // Reserved mode reports the RAW8 size so line-end handling still closes the line.
  function automatic logic [2:0] group_size(input logic [1:0] mode);
    case (mode)
      MODE_RAW10: return G_RAW10;
      MODE_RAW12: return G_RAW12;
      default:    return G_RAW8;
    endcase
  endfunction

endpackage

// File: rtl/mipi_raw_group_decode.sv
// Turns one packed byte group (byte 0 in [7:0]) into four LSB-aligned 12-bit pixels.
module mipi_raw_group_decode
  import mipi_rx_pkg::*;
(
  input  logic [8*GRP_MAX-1:0]          grp_i,
  input  logic [1:0]                    mode_i,
  output logic [PIX_W*PIX_PER_BEAT-1:0] pix_o
);

  logic [7:0] b [GRP_MAX];

  for (genvar gi = 0; gi < GRP_MAX; gi++) begin : g_byte
    assign b[gi] = grp_i[8*gi +: 8];
  end

  // Per-format bit unpacking; reserved mode yields zeros
  always_comb begin
    pix_o = '0;
    case (mode_i)
      MODE_RAW8: begin
        for (int n = 0; n < PIX_PER_BEAT; n++) pix_o[PIX_W*n +: PIX_W] = {4'h0, b[n]};
      end
      MODE_RAW10: begin
        for (int n = 0; n < PIX_PER_BEAT; n++) pix_o[PIX_W*n +: PIX_W] = {2'b00, b[n], b[4][2*n +: 2]};
      end
      MODE_RAW12: begin
        pix_o[0*PIX_W +: PIX_W] = {b[0], b[2][3:0]};
        pix_o[1*PIX_W +: PIX_W] = {b[1], b[2][7:4]};
        pix_o[2*PIX_W +: PIX_W] = {b[3], b[5][3:0]};
        pix_o[3*PIX_W +: PIX_W] = {b[4], b[5][7:4]};
      end
      default: pix_o = '0;
    endcase
  end

endmodule

// File: rtl/mipi_rx_raw_unpacker.sv
// CSI-2 RAW8/10/12 unpacker: byte accumulator between the input beats and a registered 4-pixel output.
module mipi_rx_raw_unpacker
  import mipi_rx_pkg::*;
#(
  parameter int IN_BYTES  = 4,
  parameter int ACC_BYTES = 16
) (
  input  logic                          clk_i,
  input  logic                          reset,
  input  logic [1:0]                    mode_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [8*IN_BYTES-1:0]         in_data_i,
  input  logic                          in_last_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [PIX_W*PIX_PER_BEAT-1:0] out_pix_o,
  output logic                          out_last_o,
  output logic                          err_o,
  input  logic                          err_clr_i,
  output logic                          busy_o
);

  localparam int CW = $clog2(ACC_BYTES + 1);
  localparam logic [CW-1:0] IN_CNT    = CW'(IN_BYTES);
  localparam logic [CW-1:0] READY_MAX = CW'(ACC_BYTES - IN_BYTES);

  logic [7:0]    acc_reg  [ACC_BYTES];
  logic [7:0]    acc_next [ACC_BYTES];
  logic [CW-1:0] count_reg, count_next;
  logic [1:0]    mode_reg, mode_next;
  logic          line_open_reg, line_open_next;
  logic          last_pending_reg, last_pending_next;
  logic          out_valid_reg, out_valid_next;
  logic          out_last_reg, out_last_next;
  logic [PIX_W*PIX_PER_BEAT-1:0] out_pix_reg, out_pix_next;
  logic          err_reg, err_next;

  logic          accept, rsvd_beat, append, emit, close_line, last_emit;
  logic [1:0]    eff_mode;
  logic [CW-1:0] grp_cnt, cnt_after_emit;
  logic [7:0]    in_byte [IN_BYTES];
  logic [8*GRP_MAX-1:0] grp_bytes;
  logic [PIX_W*PIX_PER_BEAT-1:0] dec_pix;

  // Handshake and emit decisions; in_ready depends on registers only
  assign in_ready_o     = (count_reg <= READY_MAX) && !last_pending_reg;
  assign accept         = in_valid_i && in_ready_o;
  assign eff_mode       = line_open_reg ? mode_reg : mode_i;  // first beat of a line uses the live mode
  assign rsvd_beat      = accept && (eff_mode == MODE_RSVD);
  assign append         = accept && !rsvd_beat;
  assign grp_cnt        = CW'(group_size(mode_reg));
  assign emit           = (mode_reg != MODE_RSVD) && (count_reg >= grp_cnt) &&
                          (!out_valid_reg || out_ready_i);
  assign cnt_after_emit = emit ? (count_reg - grp_cnt) : count_reg;
  // Line ends once the pending last beat leaves less than a full group behind
  assign close_line     = last_pending_reg && (cnt_after_emit < grp_cnt);
  assign last_emit      = emit && close_line;

  for (genvar gi = 0; gi < IN_BYTES; gi++) begin : g_in_byte
    assign in_byte[gi] = in_data_i[8*gi +: 8];
  end

  for (genvar gi = 0; gi < GRP_MAX; gi++) begin : g_grp
    assign grp_bytes[8*gi +: 8] = acc_reg[gi];
  end

  mipi_raw_group_decode u_decode (
    .grp_i  (grp_bytes),
    .mode_i (mode_reg),
    .pix_o  (dec_pix)
  );

  // Each accumulator lane: shift down by the emitted group, then overlay newly accepted bytes
  for (genvar gi = 0; gi < ACC_BYTES; gi++) begin : g_lane
    logic [7:0] sh4, sh5, sh6, lane_next;
    if (gi + 4 < ACC_BYTES) begin : g_s4
      assign sh4 = acc_reg[gi + 4];
    end else begin : g_z4
      assign sh4 = '0;
    end
    if (gi + 5 < ACC_BYTES) begin : g_s5
      assign sh5 = acc_reg[gi + 5];
    end else begin : g_z5
      assign sh5 = '0;
    end
    if (gi + 6 < ACC_BYTES) begin : g_s6
      assign sh6 = acc_reg[gi + 6];
    end else begin : g_z6
      assign sh6 = '0;
    end

    // Lane next value: shifted content, replaced by an input byte when this lane is the append target
    always_comb begin
      lane_next = acc_reg[gi];
      if (emit) begin
        case (mode_reg)
          MODE_RAW10: lane_next = sh5;
          MODE_RAW12: lane_next = sh6;
          default:    lane_next = sh4;
        endcase
      end
      if (append) begin
        for (int k = 0; k < IN_BYTES; k++) begin
          if (CW'(gi) == cnt_after_emit + CW'(k)) lane_next = in_byte[k];
        end
      end
    end

    assign acc_next[gi] = lane_next;
  end

  // Control, error and output-register next state
  always_comb begin
    count_next        = close_line ? '0 : (append ? cnt_after_emit + IN_CNT : cnt_after_emit);
    mode_next         = (accept && !line_open_reg) ? mode_i : mode_reg;
    line_open_next    = line_open_reg;
    last_pending_next = last_pending_reg;
    if (close_line) begin
      line_open_next    = 1'b0;
      last_pending_next = 1'b0;
    end else if (accept) begin
      line_open_next = 1'b1;
      if (in_last_i) last_pending_next = 1'b1;
    end

    err_next = err_reg;
    if (err_clr_i) err_next = 1'b0;
    if (rsvd_beat || (close_line && (cnt_after_emit != '0))) err_next = 1'b1;

    out_valid_next = out_valid_reg;
    out_pix_next   = out_pix_reg;
    out_last_next  = out_last_reg;
    if (emit) begin
      out_valid_next = 1'b1;
      out_pix_next   = dec_pix;
      out_last_next  = last_emit;
    end else if (out_ready_i) begin
      out_valid_next = 1'b0;
      out_last_next  = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ACC_BYTES; i++) acc_reg[i] <= '0;
      count_reg        <= '0;
      mode_reg         <= MODE_RAW8;
      line_open_reg    <= 1'b0;
      last_pending_reg <= 1'b0;
      out_valid_reg    <= 1'b0;
      out_pix_reg      <= '0;
      out_last_reg     <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      for (int i = 0; i < ACC_BYTES; i++) acc_reg[i] <= acc_next[i];
      count_reg        <= count_next;
      mode_reg         <= mode_next;
      line_open_reg    <= line_open_next;
      last_pending_reg <= last_pending_next;
      out_valid_reg    <= out_valid_next;
      out_pix_reg      <= out_pix_next;
      out_last_reg     <= out_last_next;
      err_reg          <= err_next;
    end
  end

  assign out_valid_o = out_valid_reg;
  assign out_pix_o   = out_pix_reg;
  assign out_last_o  = out_last_reg;
  assign err_o       = err_reg;
  assign busy_o      = (count_reg != '0) || line_open_reg || out_valid_reg;

endmodule

// File: tb/tb_mipi_rx_raw_unpacker.sv
// Directed bench for mipi_rx_raw_unpacker (IN_BYTES=4, ACC_BYTES=16).
module tb_mipi_rx_raw_unpacker;

  localparam int IN_BYTES = 4;

  logic                  clk_i = 1'b0;
  logic                  reset = 1'b1;
  logic [1:0]            mode_i = 2'd0;
  logic                  in_valid_i = 1'b0;
  logic                  in_ready_o;
  logic [8*IN_BYTES-1:0] in_data_i = '0;
  logic                  in_last_i = 1'b0;
  logic                  out_valid_o;
  logic                  out_ready_i = 1'b1;
  logic [47:0]           out_pix_o;
  logic                  out_last_o;
  logic                  err_o;
  logic                  err_clr_i = 1'b0;
  logic                  busy_o;

  always #5 clk_i = ~clk_i;

  mipi_rx_raw_unpacker #(.IN_BYTES(IN_BYTES), .ACC_BYTES(16)) dut (
    .clk_i       (clk_i),
    .reset       (reset),
    .mode_i      (mode_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_pix_o   (out_pix_o),
    .out_last_o  (out_last_o),
    .err_o       (err_o),
    .err_clr_i   (err_clr_i),
    .busy_o      (busy_o)
  );

  int         errors = 0;
  int         checks = 0;
  int         acc_beats = 0;
  logic [47:0] pix_q [$];
  logic        last_q [$];
  logic [7:0]  line_bytes [64];

  // Record every output transfer and accepted input beat, sampled mid-cycle
  always @(negedge clk_i) begin
    if (!reset && out_valid_o && out_ready_i) begin
      pix_q.push_back(out_pix_o);
      last_q.push_back(out_last_o);
      $display("[%0t] out beat pix=%012h last=%0b", $time, out_pix_o, out_last_o);
    end
    if (!reset && in_valid_i && in_ready_o) acc_beats++;
  end

  // Byte 0 of the line is the most significant byte of v
  task automatic load_bytes(input logic [8*32-1:0] v, input int n);
    for (int i = 0; i < n; i++) line_bytes[i] = v[8*(n-1-i) +: 8];
  endtask

  task automatic send_line(input logic [1:0] first_mode, input logic [1:0] later_mode,
                           input int nbytes, input bit with_last);
    int nbeats;
    int budget;
    nbeats = (nbytes + IN_BYTES - 1) / IN_BYTES;
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < IN_BYTES; k++)
        in_data_i[8*k +: 8] = (b*IN_BYTES + k < nbytes) ? line_bytes[b*IN_BYTES + k] : 8'h00;
      mode_i     = (b == 0) ? first_mode : later_mode;
      in_last_i  = with_last && (b == nbeats - 1);
      in_valid_i = 1'b1;
      budget = 0;
      while (!in_ready_o && budget < 200) begin
        @(posedge clk_i); #1;
        budget++;
      end
      if (!in_ready_o) begin
        checks++; errors++;
        $display("FAIL send_timeout beat=%0d in_ready=%0b required=1", b, in_ready_o);
      end
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (busy_o && budget < 500) begin
      @(posedge clk_i); #1;
      budget++;
    end
    if (busy_o) begin
      checks++; errors++;
      $display("FAIL idle_timeout busy=%0b required=0", busy_o);
    end
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_err_clr();
    err_clr_i = 1'b1;
    @(posedge clk_i); #1;
    err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid_o); end
    checks++; if (out_pix_o !== 48'h0) begin errors++; $display("FAIL rst_out_pix got=%012h exp=0", out_pix_o); end
    checks++; if (out_last_o !== 1'b0) begin errors++; $display("FAIL rst_out_last got=%0b exp=0", out_last_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got=%0b exp=0", err_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", busy_o); end
    $display("test_reset done");
  endtask

  // Four RAW10 groups; mode of later beats given separately so the mode-change test can reuse it
  task automatic raw10_line(input string tag, input logic [1:0] later_mode);
    logic [47:0] exp_pix [4];
    int q0;
    exp_pix[0] = 48'h1E3_15A_0D1_048;
    exp_pix[1] = 48'h00F_00B_007_003;
    exp_pix[2] = 48'h100_0C0_080_040;
    exp_pix[3] = 48'h340_301_2C2_283;
    q0 = pix_q.size();
    load_bytes(256'h12345678E4_00010203FF_1020304000_A0B0C0D01B, 20);
    send_line(2'd1, later_mode, 20, 1'b1);
    wait_idle();
    checks++;
    if (pix_q.size() - q0 !== 4) begin
      errors++; $display("FAIL %s_beats got=%0d exp=4", tag, pix_q.size() - q0);
    end
    for (int i = 0; i < 4 && q0 + i < pix_q.size(); i++) begin
      checks++;
      if (pix_q[q0+i] !== exp_pix[i]) begin
        errors++; $display("FAIL %s_pix%0d got=%012h exp=%012h", tag, i, pix_q[q0+i], exp_pix[i]);
      end
      checks++;
      if (last_q[q0+i] !== (i == 3)) begin
        errors++; $display("FAIL %s_last%0d got=%0b exp=%0b", tag, i, last_q[q0+i], (i == 3));
      end
    end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL %s_err got=%0b exp=0", tag, err_o); end
  endtask

  task automatic test_raw10();
    raw10_line("raw10", 2'd1);
    $display("test_raw10 done");
  endtask

  task automatic test_raw12();
    int q0;
    q0 = pix_q.size();
    load_bytes(256'hABCD21ABCD21, 6);
    send_line(2'd2, 2'd2, 6, 1'b1);  // second beat carries two zero pad bytes
    wait_idle();
    checks++; if (pix_q.size() - q0 !== 1) begin errors++; $display("FAIL raw12_beats got=%0d exp=1", pix_q.size() - q0); end
    if (pix_q.size() > q0) begin
      checks++; if (pix_q[q0] !== 48'hCD2_AB1_CD2_AB1) begin errors++; $display("FAIL raw12_pix got=%012h exp=CD2AB1CD2AB1", pix_q[q0]); end
      checks++; if (last_q[q0] !== 1'b1) begin errors++; $display("FAIL raw12_last got=%0b exp=1", last_q[q0]); end
    end
    // the two pad bytes are a non-empty residue
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL raw12_err got=%0b exp=1", err_o); end
    pulse_err_clr();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL raw12_errclr got=%0b exp=0", err_o); end
    $display("test_raw12 done");
  endtask

  task automatic test_residue();
    int q0;
    q0 = pix_q.size();
    load_bytes(256'h12345678E4AABBCC, 8);
    send_line(2'd1, 2'd1, 8, 1'b1);
    wait_idle();
    checks++; if (pix_q.size() - q0 !== 1) begin errors++; $display("FAIL residue_beats got=%0d exp=1", pix_q.size() - q0); end
    if (pix_q.size() > q0) begin
      checks++; if (pix_q[q0] !== 48'h1E3_15A_0D1_048) begin errors++; $display("FAIL residue_pix got=%012h exp=1E315A0D1048", pix_q[q0]); end
      checks++; if (last_q[q0] !== 1'b1) begin errors++; $display("FAIL residue_last got=%0b exp=1", last_q[q0]); end
    end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL residue_err got=%0b exp=1", err_o); end
    pulse_err_clr();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL residue_errclr got=%0b exp=0", err_o); end
    $display("test_residue done");
  endtask

  task automatic test_rsvd();
    int q0;
    q0 = pix_q.size();
    load_bytes(256'h01020304, 4);
    send_line(2'd3, 2'd3, 4, 1'b1);
    wait_idle();
    checks++; if (pix_q.size() - q0 !== 0) begin errors++; $display("FAIL rsvd_beats got=%0d exp=0", pix_q.size() - q0); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL rsvd_err got=%0b exp=1", err_o); end
    pulse_err_clr();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rsvd_errclr got=%0b exp=0", err_o); end
    $display("test_rsvd done");
  endtask

  task automatic test_backpressure();
    int q0;
    int a0;
    int acc_at_stall;
    logic rdy_at_stall;
    logic [47:0] exp_pix;
    acc_at_stall = 0;
    rdy_at_stall = 1'b1;
    for (int i = 0; i < 32; i++) line_bytes[i] = 8'(i);
    q0 = pix_q.size();
    a0 = acc_beats;
    fork
      send_line(2'd0, 2'd0, 32, 1'b1);
      begin
        out_ready_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        acc_at_stall = acc_beats - a0;
        rdy_at_stall = in_ready_o;
        out_ready_i  = 1'b1;
      end
    join
    wait_idle();
    // 4 bytes parked in the output register plus 16 in the accumulator
    checks++; if (acc_at_stall !== 5) begin errors++; $display("FAIL bp_accepted got=%0d exp=5", acc_at_stall); end
    checks++; if (rdy_at_stall !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%0b exp=0", rdy_at_stall); end
    checks++; if (pix_q.size() - q0 !== 8) begin errors++; $display("FAIL bp_beats got=%0d exp=8", pix_q.size() - q0); end
    for (int k = 0; k < 8 && q0 + k < pix_q.size(); k++) begin
      exp_pix = '0;
      for (int n = 0; n < 4; n++) exp_pix[12*n +: 12] = 12'(4*k + n);
      checks++;
      if (pix_q[q0+k] !== exp_pix) begin
        errors++; $display("FAIL bp_pix%0d got=%012h exp=%012h", k, pix_q[q0+k], exp_pix);
      end
      checks++;
      if (last_q[q0+k] !== (k == 7)) begin
        errors++; $display("FAIL bp_last%0d got=%0b exp=%0b", k, last_q[q0+k], (k == 7));
      end
    end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL bp_err got=%0b exp=0", err_o); end
    $display("test_backpressure done");
  endtask

  task automatic test_mode_change();
    int q0;
    raw10_line("modechg", 2'd0);  // mode_i drops to RAW8 after the first beat
    q0 = pix_q.size();
    load_bytes(256'h5A5B5C5D6A6B6C6D, 8);
    send_line(2'd0, 2'd0, 8, 1'b1);
    wait_idle();
    checks++; if (pix_q.size() - q0 !== 2) begin errors++; $display("FAIL next_raw8_beats got=%0d exp=2", pix_q.size() - q0); end
    if (pix_q.size() > q0 + 1) begin
      checks++; if (pix_q[q0] !== 48'h05D_05C_05B_05A) begin errors++; $display("FAIL next_raw8_pix0 got=%012h exp=05D05C05B05A", pix_q[q0]); end
      checks++; if (pix_q[q0+1] !== 48'h06D_06C_06B_06A) begin errors++; $display("FAIL next_raw8_pix1 got=%012h exp=06D06C06B06A", pix_q[q0+1]); end
      checks++; if (last_q[q0+1] !== 1'b1) begin errors++; $display("FAIL next_raw8_last got=%0b exp=1", last_q[q0+1]); end
    end
    $display("test_mode_change done");
  endtask

  task automatic test_reset_midline();
    int q0;
    int budget;
    out_ready_i = 1'b0;
    load_bytes(256'h0102030405060708, 8);
    send_line(2'd0, 2'd0, 8, 1'b0);
    budget = 0;
    while (!out_valid_o && budget < 50) begin
      @(posedge clk_i); #1;
      budget++;
    end
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got=%0b exp=1", out_valid_o); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0b exp=0", out_valid_o); end
    checks++; if (out_pix_o !== 48'h0) begin errors++; $display("FAIL midrst_pix got=%012h exp=0", out_pix_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b exp=0", busy_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%0b exp=1", in_ready_o); end
    @(posedge clk_i); #1;
    reset = 1'b0;
    out_ready_i = 1'b1;
    q0 = pix_q.size();
    load_bytes(256'h11223344, 4);
    send_line(2'd0, 2'd0, 4, 1'b1);
    wait_idle();
    checks++; if (pix_q.size() - q0 !== 1) begin errors++; $display("FAIL midrst_beats got=%0d exp=1", pix_q.size() - q0); end
    if (pix_q.size() > q0) begin
      checks++; if (pix_q[q0] !== 48'h044_033_022_011) begin errors++; $display("FAIL midrst_pix_after got=%012h exp=044033022011", pix_q[q0]); end
      checks++; if (last_q[q0] !== 1'b1) begin errors++; $display("FAIL midrst_last got=%0b exp=1", last_q[q0]); end
    end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL midrst_err got=%0b exp=0", err_o); end
    $display("test_reset_midline done");
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk_i); #1;
    test_raw10();
    test_raw12();
    test_residue();
    test_rsvd();
    test_backpressure();
    test_mode_change();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
